// File: rtl/led_page_scheduler_pkg.sv
// Shared constants, page index type and scheduler state encoding for the LED page scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package led_pkg;

    // Default geometry: 16 pages of 8 LEDs, 4-bit page indicator.
    localparam int PAGES        = 16;
    localparam int IDX_W        = 4;

    // Default auto-cycle dwell: 1 s at 50 MHz.
    localparam int DWELL_CYCLES = 50_000_000;
    localparam int DWELL_W      = 26;

    typedef logic [IDX_W-1:0] page_idx_t;

    // Search direction encoding for page_ring_search.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Scheduler states with fixed encodings so debug taps stay stable.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2,
        PAUSED = 2'd3
    } sched_state_t;

endpackage

// File: rtl/led_page_scheduler_ring_search.sv
// Finds the first enabled page after (up) or before (down) the current one, wrapping modulo PAGES.
// Latency: purely combinational.
// Backpressure: not applicable.
module page_ring_search
    import led_pkg::*;
#(
    parameter int N_PAGES = led_pkg::PAGES,
    parameter int N_IDX_W = led_pkg::IDX_W
) (
    input  logic [N_PAGES-1:0] i_mask,
    input  logic [N_IDX_W-1:0] i_cur,
    input  logic               i_dir,
    output logic               o_found,
    output logic [N_IDX_W-1:0] o_idx
);

    // Candidate k is the page at distance k+1 from the current one. The last
    // candidate (distance N_PAGES) wraps back onto i_cur itself, so a lone
    // enabled page finds itself.
    logic [N_IDX_W-1:0] w_cand [N_PAGES];
    logic [N_PAGES-1:0] w_rot;

    // Rotate the mask so that bit k is the enable of candidate k.
    always_comb begin
        for (int k = 0; k < N_PAGES; k++) begin
            if (i_dir == DIR_DOWN) begin
                w_cand[k] = i_cur - N_IDX_W'(k + 1);
            end else begin
                w_cand[k] = i_cur + N_IDX_W'(k + 1);
            end
            w_rot[k] = i_mask[w_cand[k]];
        end
    end

    // Priority-encode the rotated mask: the nearest enabled candidate wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_cur;
        for (int k = N_PAGES - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/led_page_scheduler.sv
// Selects the displayed status page from button steps and a timed auto-cycle, skipping masked pages.
// Latency: a step or dwell expiry in cycle N updates o_page_idx / o_page_chg in cycle N+1.
// Backpressure: none; step pulses are consumed in the cycle they arrive, simultaneous up+down is dropped.
module led_page_scheduler
    import led_pkg::*;
#(
    parameter int PAGES        = led_pkg::PAGES,
    parameter int IDX_W        = led_pkg::IDX_W,
    parameter int DWELL_CYCLES = led_pkg::DWELL_CYCLES,
    parameter int DWELL_W      = led_pkg::DWELL_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PAGES-1:0]   i_page_en,
    input  logic               i_auto_en,
    input  logic               i_hold,
    input  logic               i_step_up,
    input  logic               i_step_down,
    output logic [IDX_W-1:0]   o_page_idx,
    output logic               o_page_valid,
    output logic               o_page_chg,
    output logic [DWELL_W-1:0] o_dwell_left
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               r_chg;

    logic               w_any;
    logic               w_cur_off;
    logic               w_step_up;
    logic               w_step_dn;
    logic               w_expire;
    logic               w_auto_cur;
    logic               w_auto_nxt;
    logic               w_moved;

    logic               w_nxt_found;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic               w_prv_found;
    logic [IDX_W-1:0]   w_prv_idx;

    page_ring_search #(
        .N_PAGES (PAGES),
        .N_IDX_W (IDX_W)
    ) u_search_next (
        .i_mask  (i_page_en),
        .i_cur   (r_idx),
        .i_dir   (DIR_UP),
        .o_found (w_nxt_found),
        .o_idx   (w_nxt_idx)
    );

    page_ring_search #(
        .N_PAGES (PAGES),
        .N_IDX_W (IDX_W)
    ) u_search_prev (
        .i_mask  (i_page_en),
        .i_cur   (r_idx),
        .i_dir   (DIR_DOWN),
        .o_found (w_prv_found),
        .o_idx   (w_prv_idx)
    );

    assign w_any      = |i_page_en;
    assign w_cur_off  = ~i_page_en[r_idx];
    // Opposing steps in the same cycle cancel out.
    assign w_step_up  = i_step_up & ~i_step_down;
    assign w_step_dn  = i_step_down & ~i_step_up;
    assign w_expire   = (r_state == AUTO) && (r_dwell == '0);
    assign w_auto_cur = (r_state == AUTO) || (r_state == PAUSED);
    assign w_auto_nxt = (w_state_nxt == AUTO) || (w_state_nxt == PAUSED);

    // Next state follows the current mask and mode levels directly.
    always_comb begin
        w_state_nxt = EMPTY;
        if (!w_any) begin
            w_state_nxt = EMPTY;
        end else if (!i_auto_en) begin
            w_state_nxt = MANUAL;
        end else if (i_hold) begin
            w_state_nxt = PAUSED;
        end else begin
            w_state_nxt = AUTO;
        end
    end

    // Page and dwell update, priority: empty mask, leave-empty, disabled-page fix-up, step, expiry.
    always_comb begin
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_moved     = 1'b0;
        if (!w_any) begin
            w_idx_nxt   = '0;
            w_dwell_nxt = '0;
        end else if (r_state == EMPTY) begin
            // r_idx is 0 here, so next(0) is the lowest enabled page when page 0 is off.
            if (!i_page_en[0] && w_nxt_found) begin
                w_idx_nxt = w_nxt_idx;
            end
            w_dwell_nxt = w_auto_nxt ? DWELL_LOAD : '0;
        end else begin
            if (w_cur_off && w_nxt_found) begin
                w_idx_nxt = w_nxt_idx;
                w_moved   = 1'b1;
            end else if (w_step_up && w_nxt_found) begin
                w_idx_nxt = w_nxt_idx;
                w_moved   = 1'b1;
            end else if (w_step_dn && w_prv_found) begin
                w_idx_nxt = w_prv_idx;
                w_moved   = 1'b1;
            end else if (w_expire && w_nxt_found) begin
                w_idx_nxt = w_nxt_idx;
                w_moved   = 1'b1;
            end

            // Dwell is parked at 0 in manual mode, restarts on entry or any page move,
            // counts only while staying in AUTO, and is frozen otherwise (paused or resuming).
            if (!w_auto_nxt) begin
                w_dwell_nxt = '0;
            end else if (!w_auto_cur || w_moved) begin
                w_dwell_nxt = DWELL_LOAD;
            end else if ((r_state == AUTO) && (w_state_nxt == AUTO)) begin
                w_dwell_nxt = r_dwell - DWELL_W'(1);
            end
        end
    end

    // State registers; the change strobe fires only when the index really moves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_idx   <= '0;
            r_dwell <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_chg   <= (w_idx_nxt != r_idx);
        end
    end

    assign o_page_idx   = r_idx;
    assign o_page_valid = w_any;
    assign o_page_chg   = r_chg;
    assign o_dwell_left = r_dwell;

endmodule

// File: tb/tb_led_page_scheduler.sv
// Directed table-driven bench for led_page_scheduler with a 4-cycle dwell.
// Latency: inputs applied 1 time unit after a rising edge, outputs checked 1 unit after the next.
// Backpressure: not applicable.
module tb_led_page_scheduler;

    localparam int TB_PAGES = 16;
    localparam int TB_IDX_W = 4;
    localparam int TB_DWELL = 4;
    localparam int TB_DW_W  = 4;

    logic                clk;
    logic                rst;
    logic [TB_PAGES-1:0] page_en;
    logic                auto_en;
    logic                hold;
    logic                step_up;
    logic                step_down;
    logic [TB_IDX_W-1:0] page_idx;
    logic                page_valid;
    logic                page_chg;
    logic [TB_DW_W-1:0]  dwell_left;

    typedef struct {
        logic [15:0] en;
        logic        a;
        logic        h;
        logic        u;
        logic        d;
        logic [3:0]  idx;
        logic        chg;
        logic [3:0]  dwell;
    } vec_t;

    vec_t tbl [80];
    int   n_tbl;
    int   n_vec;
    int   n_err;

    led_page_scheduler #(
        .PAGES        (TB_PAGES),
        .IDX_W        (TB_IDX_W),
        .DWELL_CYCLES (TB_DWELL),
        .DWELL_W      (TB_DW_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_page_en    (page_en),
        .i_auto_en    (auto_en),
        .i_hold       (hold),
        .i_step_up    (step_up),
        .i_step_down  (step_down),
        .o_page_idx   (page_idx),
        .o_page_valid (page_valid),
        .o_page_chg   (page_chg),
        .o_dwell_left (dwell_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [15:0] en, input logic a, input logic h, input logic u,
                       input logic d, input logic [3:0] idx, input logic chg, input logic [3:0] dw);
        tbl[n_tbl].en    = en;
        tbl[n_tbl].a     = a;
        tbl[n_tbl].h     = h;
        tbl[n_tbl].u     = u;
        tbl[n_tbl].d     = d;
        tbl[n_tbl].idx   = idx;
        tbl[n_tbl].chg   = chg;
        tbl[n_tbl].dwell = dw;
        n_tbl++;
    endtask

    task automatic check(input string nm, input logic [3:0] ei, input logic ec,
                         input logic ev, input logic [3:0] ed);
        n_vec++;
        if (page_idx !== ei || page_chg !== ec || page_valid !== ev || dwell_left !== ed) begin
            n_err++;
            $display("FAIL %s: got idx=%0d chg=%0b valid=%0b dwell=%0d, want idx=%0d chg=%0b valid=%0b dwell=%0d",
                     nm, page_idx, page_chg, page_valid, dwell_left, ei, ec, ev, ed);
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        page_en   = 16'hFFFF;
        auto_en   = 1'b0;
        hold      = 1'b0;
        step_up   = 1'b0;
        step_down = 1'b0;
        n_tbl     = 0;
        n_vec     = 0;
        n_err     = 0;

        tick();
        tick();
        check("reset", 4'd0, 1'b0, 1'b1, 4'd0);
        rst = 1'b0;

        //  en        a     h     u     d     idx    chg   dwell
        // Manual stepping over a full mask, wrap below page 0.
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1,  1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  1'b0, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2,  1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 4'd0);
        add(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
        // Sparse mask 8011: 15 -> 0 -> 4 -> 15 -> 0, then down to 15.
        add(16'h8011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0);
        add(16'h8011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4,  1'b1, 4'd0);
        add(16'h8011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 1'b1, 4'd0);
        add(16'h8011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0);
        add(16'h8011, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 4'd0);
        add(16'h8011, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 4'd0);
        // Simultaneous up and down is dropped.
        add(16'h8011, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd0);
        // Single enabled page: fix-up onto 5, then steps leave it there.
        add(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  1'b1, 4'd0);
        add(16'h0020, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 4'd0);
        add(16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  1'b0, 4'd0);
        // Move to page 4, then disable it under mask 0110 -> 0100.
        add(16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  1'b1, 4'd0);
        add(16'h0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  1'b0, 4'd0);
        add(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8,  1'b1, 4'd0);
        // Empty mask forces page 0 and ignores steps.
        add(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0);
        add(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0);
        add(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0);
        // Auto cycling over pages 0 and 2 with a 4-cycle dwell.
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd2);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd1);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b1, 4'd3);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b0, 4'd2);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b0, 4'd1);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b0, 4'd0);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd3);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd2);
        // Hold for 10 cycles: page and dwell frozen.
        for (int i = 0; i < 10; i++) begin
            add(16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2);
        end
        // Release: resume from the frozen count.
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd2);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd1);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b1, 4'd3);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b0, 4'd2);
        // Manual step in AUTO applies at once and reloads the dwell.
        add(16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd3);
        add(16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd2);

        for (int i = 0; i < n_tbl; i++) begin
            page_en   = tbl[i].en;
            auto_en   = tbl[i].a;
            hold      = tbl[i].h;
            step_up   = tbl[i].u;
            step_down = tbl[i].d;
            tick();
            check($sformatf("vec%0d", i), tbl[i].idx, tbl[i].chg, |tbl[i].en, tbl[i].dwell);
        end
        step_up   = 1'b0;
        step_down = 1'b0;

        // Reset in the middle of AUTO with dwell_left == 2.
        rst = 1'b1;
        tick();
        check("rst_mid_auto", 4'd0, 1'b0, 1'b1, 4'd0);
        rst = 1'b0;
        tick();
        check("rst_release", 4'd0, 1'b0, 1'b1, 4'd3);
        tick();
        check("rst_count", 4'd0, 1'b0, 1'b1, 4'd2);

        // Leaving EMPTY with page 0 disabled lands on the lowest enabled page.
        page_en = 16'h0000;
        tick();
        check("empty_again", 4'd0, 1'b0, 1'b0, 4'd0);
        page_en = 16'h0600;
        auto_en = 1'b0;
        tick();
        check("leave_empty_low", 4'd9, 1'b1, 1'b1, 4'd0);
        step_down = 1'b1;
        tick();
        step_down = 1'b0;
        check("down_wrap_high", 4'd10, 1'b1, 1'b1, 4'd0);
        tick();
        check("down_settle", 4'd10, 1'b0, 1'b1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
